unique_value_serializer: RTL

Downstream consumer of the repetition detector. Accepts one group per transfer: GROUP_SIZE activations plus the GROUP_SIZE×GROUP_SIZE repetition matrix. Emits one beat per unique value, carrying the value and the lane mask of every position that holds it, so the compute stage processes each distinct activation once. Iteration-controlled by a configure pulse, like the other RTLinf stages.

---
 rtl/unique_value_serializer_pkg.sv | 28 ++
 rtl/unique_value_serializer_encoder.sv | 26 ++
 rtl/unique_value_serializer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/unique_value_serializer_pkg.sv
// Shared layout for the unique-value serializer and its upstream repetition detector.
// Holds default sizes, repetition-matrix width and data_out field offsets so both
// blocks agree on packing.
package unique_value_serializer_pkg;

  localparam int DEF_GROUP_SIZE     = 4;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_LOG_MAX_GROUPS = 16;

  // data_out = {mask, value}; value sits at the bottom.
  localparam int DOUT_VALUE_LSB = 0;

  // Repetition-info width: one bit per (row, column) pair of the group.
  function automatic int rep_width(input int group_size);
    return group_size * group_size;
  endfunction

  // Lane-mask field starts right above the value field.
  function automatic int dout_mask_lsb(input int data_width);
    return DOUT_VALUE_LSB + data_width;
  endfunction

  // Width of a lane index, never narrower than one bit.
  function automatic int idx_width(input int group_size);
    return (group_size > 1) ? $clog2(group_size) : 1;
  endfunction

endpackage

// File: rtl/unique_value_serializer_encoder.sv
// rep_priority_encoder: lowest-set-bit index of a lane vector plus any/exactly-one flags.
// Ports: vec (in), idx (lowest set bit, 0 when vec is empty), any (vec != 0),
//        one (exactly one bit set). Purely combinational.
module rep_priority_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             one
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;
  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign one = any & ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/unique_value_serializer.sv
// unique_value_serializer: takes one group (values + repetition matrix) per transfer and
// emits one {lane mask, value} beat per distinct value, lowest lane first.
// Ports: clk, rst (async active-low), configure/num_groups (iteration control),
//        data_in/valid_in/avail_out (group input), data_out/last_out/valid_out/avail_in
//        (beat output), done_out, error_out.
// Optional matrix checker enabled by defining UNIQUE_SERIALIZER_CHECK_EN; otherwise
// error_out is tied low.
module unique_value_serializer
  import unique_value_serializer_pkg::*;
#(
  parameter int GROUP_SIZE     = DEF_GROUP_SIZE,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LOG_MAX_GROUPS = DEF_LOG_MAX_GROUPS
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  configure,
  input  logic [LOG_MAX_GROUPS-1:0]                             num_groups,
  input  logic [GROUP_SIZE*DATA_WIDTH+GROUP_SIZE*GROUP_SIZE-1:0] data_in,
  input  logic                                                  valid_in,
  output logic                                                  avail_out,
  output logic [GROUP_SIZE+DATA_WIDTH-1:0]                      data_out,
  output logic                                                  last_out,
  output logic                                                  valid_out,
  input  logic                                                  avail_in,
  output logic                                                  done_out,
  output logic                                                  error_out
);

  localparam int REP_W = rep_width(GROUP_SIZE);
  localparam int VAL_W = GROUP_SIZE * DATA_WIDTH;
  localparam int IDX_W = idx_width(GROUP_SIZE);

  logic [VAL_W+REP_W-1:0]    in_buf;
  logic                      in_buf_v;
  logic [VAL_W-1:0]          work_vals;
  logic [REP_W-1:0]          work_mat;
  logic [GROUP_SIZE-1:0]     pending;
  logic                      work_v;
  logic                      enabled_r;
  logic [LOG_MAX_GROUPS-1:0] groups_left_r;

  logic [GROUP_SIZE-1:0]     row_nz;
  logic [IDX_W-1:0]          enc_idx;
  logic                      pend_any, pend_one;
  logic                      accept, fire, handoff, load;
  logic [GROUP_SIZE-1:0]     cur_row;
  logic [DATA_WIDTH-1:0]     cur_val;

  // A lane is a representative (needs a beat) iff its matrix row is non-zero.
  always_comb begin
    row_nz = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      row_nz[i] = |in_buf[VAL_W + i*GROUP_SIZE +: GROUP_SIZE];
    end
  end

  rep_priority_encoder #(.WIDTH(GROUP_SIZE), .IDX_W(IDX_W)) u_enc (
    .vec (pending),
    .idx (enc_idx),
    .any (pend_any),
    .one (pend_one)
  );

  assign cur_row   = work_mat[int'(enc_idx)*GROUP_SIZE +: GROUP_SIZE];
  assign cur_val   = work_vals[int'(enc_idx)*DATA_WIDTH +: DATA_WIDTH];

  assign avail_out = enabled_r & ~in_buf_v & (groups_left_r != '0);
  assign valid_out = work_v & pend_any;
  assign last_out  = valid_out & pend_one;
  assign done_out  = enabled_r & (groups_left_r == '0) & ~in_buf_v & ~work_v;

  always_comb begin
    data_out = '0;
    if (valid_out) begin
      data_out[DOUT_VALUE_LSB +: DATA_WIDTH]            = cur_val;
      data_out[dout_mask_lsb(DATA_WIDTH) +: GROUP_SIZE] = cur_row;
    end
  end

  assign accept  = valid_in & avail_out;
  assign fire    = valid_out & avail_in;
  assign handoff = fire & last_out;
  // Work is free when empty, when holding an empty (all-zero) group, or when its
  // last beat leaves this cycle; an empty group is thus dropped without a beat.
  assign load    = in_buf_v & (~work_v | ~pend_any | handoff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_buf        <= '0;
      in_buf_v      <= 1'b0;
      work_vals     <= '0;
      work_mat      <= '0;
      pending       <= '0;
      work_v        <= 1'b0;
      enabled_r     <= 1'b0;
      groups_left_r <= '0;
    end else if (configure) begin
      groups_left_r <= num_groups;
      enabled_r     <= 1'b1;
      in_buf_v      <= 1'b0;
      work_v        <= 1'b0;
      pending       <= '0;
    end else begin
      if (done_out) enabled_r <= 1'b0;

      // accept needs in_buf empty and load needs it full, so they never collide.
      if (accept) begin
        in_buf        <= data_in;
        in_buf_v      <= 1'b1;
        groups_left_r <= groups_left_r - LOG_MAX_GROUPS'(1);
      end else if (load) begin
        in_buf_v <= 1'b0;
      end

      if (load) begin
        work_vals <= in_buf[VAL_W-1:0];
        work_mat  <= in_buf[VAL_W +: REP_W];
        pending   <= row_nz;
        work_v    <= 1'b1;
      end else if (work_v && !pend_any) begin
        work_v <= 1'b0;
      end else if (fire) begin
        pending[enc_idx] <= 1'b0;
        if (pend_one) work_v <= 1'b0;
      end
    end
  end

`ifdef UNIQUE_SERIALIZER_CHECK_EN
  logic error_r;

  // A well-formed matrix is upper-triangular, each column has exactly one 1
  // (each lane belongs to exactly one representative) and lane 0 is always one.
  function automatic logic mat_fault(input logic [REP_W-1:0] m);
    logic f;
    int   cnt;
    f = 1'b0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      for (int j = 0; j < i; j++) begin
        if (m[i*GROUP_SIZE + j]) f = 1'b1;
      end
    end
    for (int j = 0; j < GROUP_SIZE; j++) begin
      cnt = 0;
      for (int i = 0; i < GROUP_SIZE; i++) cnt += int'(m[i*GROUP_SIZE + j]);
      if (cnt != 1) f = 1'b1;
    end
    if (m[GROUP_SIZE-1:0] == '0) f = 1'b1;
    return f;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         error_r <= 1'b0;
    else if (configure)                               error_r <= 1'b0;
    else if (load && mat_fault(in_buf[VAL_W +: REP_W])) error_r <= 1'b1;
  end

  assign error_out = error_r;
`else
  assign error_out = 1'b0;
`endif

endmodule
